// File: rtl/mod_count_monitor.sv
// Receive-side checker for the loadable modulo up/down counter: infers direction and lock, flags bad steps.
// Optional macro MON_ERR_CLR_EN adds a synchronous err_clr input for err_count.
module mod_count_monitor #(
    parameter int WIDTH = 3,
    parameter int MAX   = 4,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sample_valid,
    input  logic [WIDTH-1:0] sample,
    input  logic             load_flag,
`ifdef MON_ERR_CLR_EN
    input  logic             err_clr,
`endif
    output logic             locked,
    output logic             dir_up,
    output logic             step_err,
    output logic             reversal,
    output logic             stall,
    output logic [ERR_W-1:0] err_count
);

    // state      | meaning
    // IDLE       | no usable history, waiting for an in-range sample
    // ACQUIRE    | have one reference sample, waiting for a legal step
    // TRACK_UP   | locked, counter incrementing
    // TRACK_DOWN | locked, counter decrementing
    typedef enum logic [1:0] {IDLE, ACQUIRE, TRACK_UP, TRACK_DOWN} state_t;

    localparam logic [WIDTH-1:0] MAX_V   = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] ONE_V   = WIDTH'(1);
    localparam logic [ERR_W-1:0] ERR_SAT = '1;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic             locked_q, locked_d;
    logic             dir_q, dir_d;
    logic             step_err_q, step_err_d;
    logic             rev_q, rev_d;
    logic             stall_q, stall_d;
    logic [ERR_W-1:0] cnt_q, cnt_d;

    logic [WIDTH-1:0] up_val, down_val;
    logic             is_oor, is_up, is_down, is_hold;

    assign up_val   = (prev_q == MAX_V) ? '0 : prev_q + ONE_V;
    assign down_val = (prev_q == '0) ? MAX_V : prev_q - ONE_V;
    assign is_oor   = (sample > MAX_V);
    assign is_up    = (sample == up_val);
    assign is_down  = (sample == down_val);
    assign is_hold  = (sample == prev_q);

    always_comb begin
        state_d    = state_q;
        prev_d     = prev_q;
        dir_d      = dir_q;
        step_err_d = 1'b0;
        rev_d      = 1'b0;
        stall_d    = 1'b0;
        cnt_d      = cnt_q;

        if (sample_valid) begin
            if (is_oor) begin
                step_err_d = 1'b1;
                state_d    = IDLE;
            end else begin
                prev_d = sample;
                unique case (state_q)
                    IDLE: state_d = ACQUIRE;
                    ACQUIRE: begin
                        if (is_up) begin
                            state_d = TRACK_UP;
                            dir_d   = 1'b1;
                        end else if (is_down) begin
                            state_d = TRACK_DOWN;
                            dir_d   = 1'b0;
                        end else if (is_hold) begin
                            stall_d = 1'b1;
                        end else begin
                            step_err_d = ~load_flag;
                        end
                    end
                    TRACK_UP: begin
                        if (is_up) begin
                            state_d = TRACK_UP;
                        end else if (is_down) begin
                            rev_d   = 1'b1;
                            state_d = TRACK_DOWN;
                            dir_d   = 1'b0;
                        end else if (is_hold) begin
                            stall_d = 1'b1;
                        end else begin
                            step_err_d = ~load_flag;
                            state_d    = ACQUIRE;
                        end
                    end
                    TRACK_DOWN: begin
                        if (is_down) begin
                            state_d = TRACK_DOWN;
                        end else if (is_up) begin
                            rev_d   = 1'b1;
                            state_d = TRACK_UP;
                            dir_d   = 1'b1;
                        end else if (is_hold) begin
                            stall_d = 1'b1;
                        end else begin
                            step_err_d = ~load_flag;
                            state_d    = ACQUIRE;
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end
        end

        if (step_err_d && (cnt_q != ERR_SAT)) begin
            cnt_d = cnt_q + ERR_W'(1);
        end
`ifdef MON_ERR_CLR_EN
        // Clear wins over the old value but still counts a coincident error.
        if (err_clr) begin
            cnt_d = step_err_d ? ERR_W'(1) : '0;
        end
`endif
        locked_d = (state_d == TRACK_UP) || (state_d == TRACK_DOWN);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            prev_q     <= '0;
            locked_q   <= 1'b0;
            dir_q      <= 1'b0;
            step_err_q <= 1'b0;
            rev_q      <= 1'b0;
            stall_q    <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            prev_q     <= prev_d;
            locked_q   <= locked_d;
            dir_q      <= dir_d;
            step_err_q <= step_err_d;
            rev_q      <= rev_d;
            stall_q    <= stall_d;
            cnt_q      <= cnt_d;
        end
    end

    assign locked    = locked_q;
    assign dir_up    = dir_q;
    assign step_err  = step_err_q;
    assign reversal  = rev_q;
    assign stall     = stall_q;
    assign err_count = cnt_q;

endmodule

// File: tb/tb_mod_count_monitor.sv
// Bench for mod_count_monitor: modular-arithmetic reference model checked every cycle plus literal spot checks.
module tb_mod_count_monitor;
    localparam int WIDTH = 3;
    localparam int MAX   = 4;
    localparam int ERR_W = 8;
    localparam int SAT   = (1 << ERR_W) - 1;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             sample_valid = 1'b0;
    logic [WIDTH-1:0] sample = '0;
    logic             load_flag = 1'b0;
    logic             err_clr = 1'b0;
    logic             locked, dir_up, step_err, reversal, stall;
    logic [ERR_W-1:0] err_count;

    int n_checks = 0;
    int n_err = 0;

    mod_count_monitor #(.WIDTH(WIDTH), .MAX(MAX), .ERR_W(ERR_W)) dut (
        .clk(clk),
        .reset(reset),
        .sample_valid(sample_valid),
        .sample(sample),
        .load_flag(load_flag),
`ifdef MON_ERR_CLR_EN
        .err_clr(err_clr),
`endif
        .locked(locked),
        .dir_up(dir_up),
        .step_err(step_err),
        .reversal(reversal),
        .stall(stall),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    // Reference model: mode 0 = no history, 1 = have reference, 2 = locked
    int m_mode, m_prev, m_up, m_cnt, e_err, e_rev, e_stall;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_mode = 0; m_prev = 0; m_up = 0; m_cnt = 0;
            e_err = 0; e_rev = 0; e_stall = 0;
        end else begin
            int s, d;
            e_err = 0; e_rev = 0; e_stall = 0;
            if (sample_valid) begin
                s = int'(sample);
                if (s > MAX) begin
                    e_err = 1;
                    m_mode = 0;
                end else begin
                    d = (s - m_prev + MAX + 1) % (MAX + 1);
                    if (m_mode == 0) begin
                        m_mode = 1;
                    end else if (d == 1 || d == MAX) begin
                        if (m_mode == 2 && m_up != int'(d == 1)) e_rev = 1;
                        m_mode = 2;
                        m_up = int'(d == 1);
                    end else if (d == 0) begin
                        e_stall = 1;
                    end else begin
                        if (!load_flag) e_err = 1;
                        m_mode = 1;
                    end
                    m_prev = s;
                end
            end
            if (e_err != 0 && m_cnt < SAT) m_cnt = m_cnt + 1;
`ifdef MON_ERR_CLR_EN
            if (err_clr) m_cnt = e_err;
`endif
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("model_locked", int'(locked), int'(m_mode == 2));
        chk("model_dir_up", int'(dir_up), m_up);
        chk("model_step_err", int'(step_err), e_err);
        chk("model_reversal", int'(reversal), e_rev);
        chk("model_stall", int'(stall), e_stall);
        chk("model_err_count", int'(err_count), m_cnt);
    end

    task automatic send(input bit v, input int s, input bit l);
        @(negedge clk);
        sample_valid = v;
        sample = WIDTH'(s);
        load_flag = l;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #12;
        chk("reset_locked", int'(locked), 0);
        chk("reset_err_count", int'(err_count), 0);
        @(negedge clk);
        reset = 1'b1;

        // Count up with wrap
        send(1, 0, 0);
        send(1, 1, 0);
        chk("lock_after_1", int'(locked), 1);
        chk("dir_up_after_1", int'(dir_up), 1);
        send(1, 2, 0); send(1, 3, 0); send(1, 4, 0);
        send(1, 0, 0);
        chk("wrap_up_no_err", int'(step_err), 0);
        send(1, 1, 0);
        chk("up_seq_err_count", int'(err_count), 0);

        // Count down with wrap, then reverse
        send(1, 2, 0); send(1, 1, 0); send(1, 0, 0);
        send(1, 4, 0);
        chk("wrap_down_no_err", int'(step_err), 0);
        chk("down_dir", int'(dir_up), 0);
        send(1, 3, 0);
        send(1, 4, 0);
        chk("reversal_at_4", int'(reversal), 1);
        chk("dir_after_rev", int'(dir_up), 1);
        send(1, 0, 0);
        chk("no_rev_at_0", int'(reversal), 0);
        chk("down_seq_err_count", int'(err_count), 0);

        // Illegal jump, then resync
        send(1, 1, 0);
        send(1, 3, 0);
        chk("jump_step_err", int'(step_err), 1);
        chk("jump_unlock", int'(locked), 0);
        chk("jump_err_count", int'(err_count), 1);
        send(1, 4, 0);
        chk("relock_up", int'(locked), 1);

        // Loaded jump
        send(1, 0, 0); send(1, 1, 0); send(1, 2, 0);
        send(1, 0, 1);
        chk("load_no_err", int'(step_err), 0);
        chk("load_unlock", int'(locked), 0);
        send(1, 1, 0);
        send(1, 0, 0);
        chk("relock_down", int'(locked), 1);
        chk("relock_down_dir", int'(dir_up), 0);

        // load_flag on a legal step is ignored; idle cycle changes nothing
        send(1, 4, 1);
        chk("load_on_step_locked", int'(locked), 1);
        send(0, 2, 0);
        chk("idle_locked", int'(locked), 1);

        // Stall in TRACK_UP
        send(1, 0, 0); send(1, 1, 0); send(1, 2, 0); send(1, 3, 0);
        send(1, 3, 0);
        chk("stall_pulse", int'(stall), 1);
        chk("stall_locked", int'(locked), 1);
        send(1, 4, 0);
        chk("stall_one_cycle", int'(stall), 0);

        // Out-of-range and saturation
        send(1, 6, 0);
        chk("oor_step_err", int'(step_err), 1);
        chk("oor_unlock", int'(locked), 0);
        chk("oor_err_count", int'(err_count), 2);
        for (int i = 0; i < 255; i++) send(1, 5 + (i % 3), 0);
        chk("err_saturate", int'(err_count), SAT);
        send(1, 0, 0);
        send(1, 1, 0);
        chk("relock_after_oor", int'(locked), 1);

`ifdef MON_ERR_CLR_EN
        @(negedge clk);
        err_clr = 1'b1;
        sample_valid = 1'b1; sample = WIDTH'(7); load_flag = 1'b0;
        @(posedge clk); #1;
        err_clr = 1'b0;
        chk("clr_with_err", int'(err_count), 1);
`endif

        // Asynchronous reset mid-stream
        send(1, 2, 0);
        send(1, 7, 0);
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_locked", int'(locked), 0);
        chk("async_rst_step_err", int'(step_err), 0);
        chk("async_rst_err_count", int'(err_count), 0);
        @(negedge clk);
        sample_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        send(1, 3, 0);
        send(1, 2, 0);
        chk("post_rst_lock", int'(locked), 1);
        chk("post_rst_dir", int'(dir_up), 0);
        send(0, 0, 0);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/mod_count_monitor.md
Name: mod_count_monitor

Overview:
- Receive-side checker for the team's loadable modulo up/down counter.
- Samples the counter's output value each cycle and infers count direction (up or down) and lock status.
- Flags illegal steps, out-of-range values, direction reversals and stalls, and keeps a saturating error count.
- Sits beside the counter in benches and in-system self-check.

Parameters:
- WIDTH, 3, sample width in bits.
- MAX, 4, highest legal count value; legal range is 0..MAX. MAX >= 2 and MAX <= 2**WIDTH-1 are required.
- ERR_W, 8, width of err_count.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- sample_valid  input  1  sample and load_flag are meaningful this cycle.
- sample  input  WIDTH  observed counter value.
- load_flag  input  1  counter performed a parallel load producing this sample; any in-range jump is legal.
- locked  output  1  high in TRACK_UP or TRACK_DOWN.
- dir_up  output  1  1 = counting up, 0 = counting down; holds last tracked direction outside TRACK states.
- step_err  output  1  one-cycle pulse, illegal sample detected.
- reversal  output  1  one-cycle pulse, direction change while locked.
- stall  output  1  one-cycle pulse, sample equal to previous sample.
- err_count  output  ERR_W  count of step_err pulses, saturating at 2**ERR_W-1.

Behaviour:
- Reset (reset=0, asynchronous):
  - State = IDLE; prev = 0.
  - Outputs: locked=0, dir_up=0, step_err=0, reversal=0, stall=0, err_count=0.
  - Reset mid-operation discards all history immediately.
- All outputs are registered. A sample presented in cycle N is reflected in outputs after rising edge N+1.
- Pulse outputs are high for exactly one cycle per offending sample. Cycles with sample_valid=0 change nothing and pulses return to 0.
- Step classification, relative to prev:
  - UP: sample == (prev==MAX ? 0 : prev+1).
  - DOWN: sample == (prev==0 ? MAX : prev-1).
  - HOLD: sample == prev.
  - JUMP: any other value.
  - OOR: sample > MAX. OOR takes priority over every other class.
- States: IDLE, ACQUIRE, TRACK_UP, TRACK_DOWN.
- IDLE:
  - valid in-range sample -> prev=sample, go to ACQUIRE.
  - OOR -> step_err, stay in IDLE.
- ACQUIRE:
  - UP -> TRACK_UP, dir_up=1.
  - DOWN -> TRACK_DOWN, dir_up=0.
  - HOLD -> stall pulse, stay in ACQUIRE.
  - JUMP with load_flag=1 -> stay in ACQUIRE, no error.
  - JUMP with load_flag=0 -> step_err, stay in ACQUIRE (resync).
- TRACK_UP:
  - UP -> stay.
  - DOWN -> reversal pulse, go to TRACK_DOWN, dir_up=0.
  - HOLD -> stall pulse, stay.
  - JUMP with load_flag -> ACQUIRE, no error.
  - JUMP without load_flag -> step_err, go to ACQUIRE.
- TRACK_DOWN: mirror of TRACK_UP.
- In any state, an OOR sample -> step_err, go to IDLE, prev unchanged.
- load_flag=1 with an UP, DOWN or HOLD step is classified as that step; the flag is ignored.
- prev updates to sample on every valid in-range sample, in every state.
- err_count increments on each step_err and holds once saturated at 2**ERR_W-1.

Optional Feature:
- Macro: MON_ERR_CLR_EN.
- Defined:
  - Adds input port err_clr (1 bit); synchronous clear of err_count on the next rising edge.
  - If err_clr and step_err fire in the same cycle, err_count becomes 1.
  - err_clr does not affect state or pulse outputs.
- Undefined:
  - No err_clr port.
  - err_count is cleared only by reset.

Test Plan:
- Reset release, then samples 0,1,2,3,4,0,1 -> locked=1 from the cycle after sample 1, dir_up=1, wrap 4->0 gives no step_err, err_count=0.
- Samples 2,1,0,4,3 -> TRACK_DOWN, dir_up=0, wrap 0->4 is legal. Then samples 4,0 -> reversal pulse once at 4 (dir_up=1 after), no reversal at 0, err_count=0.
- Locked up at 1, sample 3 with load_flag=0 -> step_err, locked=0, err_count=1. Next sample 4 -> TRACK_UP again.
- Locked at 2, sample 0 with load_flag=1 -> no step_err, locked=0. Then samples 1,0 -> TRACK_DOWN.
- Sample 6 (OOR) while locked -> step_err, IDLE, locked=0. Then 255 further step_err events -> err_count saturates at 255. Assert reset mid-stream -> all outputs 0 immediately.
- Samples 3,3 while in TRACK_UP -> stall pulse for exactly one cycle, locked stays 1. With MON_ERR_CLR_EN defined, err_clr asserted in the same cycle as a step_err -> err_count=1.
